fetch_pc_sequencer: RTL and testbench
=====================================

Name: fetch_pc_sequencer

Overview:
Owns the architectural fetch PC register and sequences instruction fetch.
- Consumes the redirect decision (take_new_pc, pc_new, flush_pipeline) produced by the next-PC decision logic, plus a pipeline stall.
- Generates the fetch address, the fetch-valid qualifier and a timed squash window that kills wrong-path instructions in the front-end stages.
- Keeps a saturating mispredict-redirect counter for performance monitoring.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
PC_STEP, 4, sequential increment in bytes
FLUSH_CYCLES, 2, number of advancing cycles the squash window lasts after a flush redirect (1..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
stall  input  1  front-end hold; PC and squash counter freeze
take_new_pc  input  1  redirect request, qualified by pc_new
pc_new  input  32  redirect target
flush_pipeline  input  1  redirect is a misprediction recovery
pc_fetch  output  32  current fetch address (registered)
pc_next  output  32  combinational value pc_fetch will take at the next edge
fetch_valid  output  1  pc_fetch is a valid fetch this cycle
squash  output  1  kill front-end pipeline registers this cycle
seq_state  output  2  FSM state: 0 BOOT, 1 RUN, 2 FLUSH
mispredict_count  output  16  saturating count of accepted flush redirects

Behaviour:
Reset (asynchronous, any time, including mid-FLUSH):
- pc_fetch=RESET_PC, seq_state=BOOT, fetch_valid=0, squash=0.
- flush counter=0, mispredict_count=0.

FSM:
- BOOT: one cycle, inputs ignored. pc_fetch held at RESET_PC. Next state is RUN; first valid fetch of RESET_PC occurs in RUN.
- RUN: fetch_valid=~stall, squash=0.
- FLUSH: fetch_valid=~stall, squash=1. The counter is loaded with FLUSH_CYCLES-1 on entry and decrements on each non-stalled cycle. Exits to RUN at the edge where counter==0 and stall=0.

PC update priority, evaluated each edge in RUN/FLUSH:
1. take_new_pc & flush_pipeline: pc_fetch<=pc_new; state<=FLUSH; counter reloaded to FLUSH_CYCLES-1; mispredict_count+=1, saturating at 16'hFFFF.
   - Applied even when stall=1; a recovery redirect is never dropped.
   - A new flush while already in FLUSH restarts the window.
2. stall: pc_fetch, counter and state hold. A non-flush take_new_pc is ignored, because the predictor re-presents it for the held PC.
3. take_new_pc (flush_pipeline=0, predicted-taken): pc_fetch<=pc_new; no state change.
4. Otherwise: pc_fetch<=pc_fetch+PC_STEP, modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000).

Other rules:
- flush_pipeline=1 with take_new_pc=0 is illegal and treated as no redirect. Verification asserts that it never occurs.
- pc_next mirrors the priority above combinationally; in BOOT it equals RESET_PC.
- Latency: redirect target appears on pc_fetch one cycle after the request edge. squash asserts in that same cycle.
- No X propagation: all outputs are driven in every state.

Test Plan:
- Reset release, no stall: cycle0 BOOT pc=0 valid=0; cycle1 RUN pc=0 valid=1; cycle2 pc=4; cycle3 pc=8.
- Predicted-taken redirect: at pc=0x10, take_new_pc=1, flush=0, pc_new=0x100 -> next pc=0x100, squash=0, state RUN, count unchanged.
- Mispredict flush at pc=0x20 with pc_new=0x400, FLUSH_CYCLES=2 -> pc 0x400 then 0x404 with squash=1 for two cycles, then RUN at 0x408; mispredict_count=1.
- Flush coincident with stall=1 -> pc_fetch=pc_new next cycle, fetch_valid=0, squash held high until stall drops, then two advancing cycles before RUN.
- Second flush during FLUSH window (pc_new=0x800) -> counter restarts, squash stays high two more advancing cycles, count=2. Async rst mid-FLUSH -> immediate pc=RESET_PC, squash=0, count=0.
- Wrap and saturation: pc=0xFFFF_FFFC increments to 0x0; force 65536 flushes -> mispredict_count stays 0xFFFF.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_sequencer
// Description : Fetch PC register with redirect priority, squash window FSM
//               and saturating mispredict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        take_new_pc,
    input  logic [31:0] pc_new,
    input  logic        flush_pipeline,
    output logic [31:0] pc_fetch,
    output logic [31:0] pc_next,
    output logic        fetch_valid,
    output logic        squash,
    output logic [1:0]  seq_state,
    output logic [15:0] mispredict_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] c_PC_STEP    = 32'(PC_STEP);
    localparam logic [3:0]  c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [15:0] r_mcount;
    logic [15:0] w_mcount_next;
    logic        w_recover;

    // Flush without a redirect is not a recovery; it degrades to no redirect.
    assign w_recover = take_new_pc & flush_pipeline;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_cnt    <= 4'd0;
            r_mcount <= 16'd0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= pc_next;
            r_cnt    <= w_cnt_next;
            r_mcount <= w_mcount_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        pc_next       = r_pc;
        w_cnt_next    = r_cnt;
        w_mcount_next = r_mcount;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
                pc_next      = RESET_PC;
            end
            ST_RUN, ST_FLUSH: begin
                // Recovery redirects win even over stall so they are never lost.
                if (w_recover) begin
                    pc_next      = pc_new;
                    w_state_next = ST_FLUSH;
                    w_cnt_next   = c_FLUSH_LOAD;
                    if (r_mcount != 16'hFFFF) begin
                        w_mcount_next = r_mcount + 16'd1;
                    end
                end else if (!stall) begin
                    pc_next = take_new_pc ? pc_new : (r_pc + c_PC_STEP);
                    if (r_state == ST_FLUSH) begin
                        if (r_cnt == 4'd0) begin
                            w_state_next = ST_RUN;
                        end else begin
                            w_cnt_next = r_cnt - 4'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_BOOT;
                pc_next      = RESET_PC;
            end
        endcase
    end

    assign pc_fetch         = r_pc;
    assign fetch_valid      = ((r_state == ST_RUN) || (r_state == ST_FLUSH)) & ~stall;
    assign squash           = (r_state == ST_FLUSH);
    assign seq_state        = r_state;
    assign mispredict_count = r_mcount;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_sequencer
// Description : Scoreboard bench for fetch_pc_sequencer (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        take_new_pc;
    logic [31:0] pc_new;
    logic        flush_pipeline;
    logic [31:0] pc_fetch;
    logic [31:0] pc_next;
    logic        fetch_valid;
    logic        squash;
    logic [1:0]  seq_state;
    logic [15:0] mispredict_count;

    fetch_pc_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .take_new_pc      (take_new_pc),
        .pc_new           (pc_new),
        .flush_pipeline   (flush_pipeline),
        .pc_fetch         (pc_fetch),
        .pc_next          (pc_next),
        .fetch_valid      (fetch_valid),
        .squash           (squash),
        .seq_state        (seq_state),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (rst) !(flush_pipeline && !take_new_pc))
        else $error("illegal flush_pipeline without take_new_pc");

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nx;
        logic        v;
        logic        sq;
        logic [1:0]  st;
        logic [15:0] cnt;
    } obs_t;

    typedef struct packed {
        logic        s;
        logic        t;
        logic        f;
        logic [31:0] pn;
        obs_t        e;
    } row_t;

    obs_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic obs_t observe();
        obs_t o;
        o.pc  = pc_fetch;
        o.nx  = pc_next;
        o.v   = fetch_valid;
        o.sq  = squash;
        o.st  = seq_state;
        o.cnt = mispredict_count;
        return o;
    endfunction

    function automatic row_t mk(logic s, logic t, logic f, logic [31:0] pn,
                                logic [31:0] pc, logic [31:0] nx, logic v,
                                logic sq, logic [1:0] st, logic [15:0] cnt);
        row_t r;
        r.s = s; r.t = t; r.f = f; r.pn = pn;
        r.e.pc = pc; r.e.nx = nx; r.e.v = v; r.e.sq = sq; r.e.st = st; r.e.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic s, input logic t, input logic f, input logic [31:0] pn);
        stall          = s;
        take_new_pc    = t;
        flush_pipeline = f;
        pc_new         = pn;
    endtask

    task automatic test_reset();
        row_t rq[$];
        obs_t got, e;
        drive(0, 0, 0, 32'h0);
        rst = 1'b1;
        q.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 0, 2'd0, 16'd0).e);
        @(negedge clk);
        got = observe(); e = q.pop_front(); nvec++;
        if (got !== e) begin
            nerr++;
            $display("FAIL reset_hold got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                     got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rq.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 0, 2'd0, 16'd0));
        rq.push_back(mk(0,0,0,0, 32'h0, 32'h4, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0, 32'h4, 32'h8, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0, 32'h8, 32'hC, 1, 0, 2'd1, 16'd0));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i].s, rq[i].t, rq[i].f, rq[i].pn);
            q.push_back(rq[i].e);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL boot[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_taken_redirect();
        row_t rq[$];
        obs_t got, e;
        rq.push_back(mk(0,0,0,0,           32'hC,   32'h10,  1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,1,0,32'h100,     32'h10,  32'h100, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0,           32'h100, 32'h104, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(1,1,0,32'h200,     32'h104, 32'h104, 0, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0,           32'h104, 32'h108, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,1,0,32'h20,      32'h108, 32'h20,  1, 0, 2'd1, 16'd0));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i].s, rq[i].t, rq[i].f, rq[i].pn);
            q.push_back(rq[i].e);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL taken[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mispredict_flush();
        row_t rq[$];
        obs_t got, e;
        rq.push_back(mk(0,1,1,32'h400, 32'h20,  32'h400, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0,       32'h400, 32'h404, 1, 1, 2'd2, 16'd1));
        rq.push_back(mk(0,0,0,0,       32'h404, 32'h408, 1, 1, 2'd2, 16'd1));
        rq.push_back(mk(0,0,0,0,       32'h408, 32'h40C, 1, 0, 2'd1, 16'd1));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i].s, rq[i].t, rq[i].f, rq[i].pn);
            q.push_back(rq[i].e);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL flush[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_stall();
        row_t rq[$];
        obs_t got, e;
        rq.push_back(mk(1,1,1,32'h600, 32'h40C, 32'h600, 0, 0, 2'd1, 16'd1));
        rq.push_back(mk(1,0,0,0,       32'h600, 32'h600, 0, 1, 2'd2, 16'd2));
        rq.push_back(mk(1,0,0,0,       32'h600, 32'h600, 0, 1, 2'd2, 16'd2));
        rq.push_back(mk(0,0,0,0,       32'h600, 32'h604, 1, 1, 2'd2, 16'd2));
        rq.push_back(mk(0,0,0,0,       32'h604, 32'h608, 1, 1, 2'd2, 16'd2));
        rq.push_back(mk(0,0,0,0,       32'h608, 32'h60C, 1, 0, 2'd1, 16'd2));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i].s, rq[i].t, rq[i].f, rq[i].pn);
            q.push_back(rq[i].e);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL flush_stall[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rq[$];
        obs_t got, e;
        rq.push_back(mk(0,1,1,32'h700, 32'h60C, 32'h700, 1, 0, 2'd1, 16'd2));
        rq.push_back(mk(0,1,1,32'h800, 32'h700, 32'h800, 1, 1, 2'd2, 16'd3));
        rq.push_back(mk(0,0,0,0,       32'h800, 32'h804, 1, 1, 2'd2, 16'd4));
        rq.push_back(mk(0,0,0,0,       32'h804, 32'h808, 1, 1, 2'd2, 16'd4));
        rq.push_back(mk(0,0,0,0,       32'h808, 32'h80C, 1, 0, 2'd1, 16'd4));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i].s, rq[i].t, rq[i].f, rq[i].pn);
            q.push_back(rq[i].e);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL reflush[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        row_t rq[$];
        obs_t got, e;
        rq.push_back(mk(0,1,1,32'h900, 32'h80C, 32'h900, 1, 0, 2'd1, 16'd4));
        rq.push_back(mk(0,0,0,0,       32'h900, 32'h904, 1, 1, 2'd2, 16'd5));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i].s, rq[i].t, rq[i].f, rq[i].pn);
            q.push_back(rq[i].e);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL pre_rst[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
        // Still inside the flush window here; reset lands between clock edges.
        #2;
        rst = 1'b1;
        q.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 0, 2'd0, 16'd0).e);
        #1;
        got = observe(); e = q.pop_front(); nvec++;
        if (got !== e) begin
            nerr++;
            $display("FAIL async_rst got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                     got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        row_t rq[$];
        obs_t got, e;
        rq.push_back(mk(0,0,0,0,            32'h0,         32'h0,         0, 0, 2'd0, 16'd0));
        rq.push_back(mk(0,1,0,32'hFFFF_FFF8, 32'h0,        32'hFFFF_FFF8, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0,            32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0,            32'hFFFF_FFFC, 32'h0,         1, 0, 2'd1, 16'd0));
        rq.push_back(mk(0,0,0,0,            32'h0,         32'h4,         1, 0, 2'd1, 16'd0));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i].s, rq[i].t, rq[i].f, rq[i].pn);
            q.push_back(rq[i].e);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL wrap[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        obs_t got, e;
        obs_t ex[3];
        ex[0] = mk(0,0,0,0, 32'h1000, 32'h1000, 1, 1, 2'd2, 16'hFFFE).e;
        ex[1] = mk(0,0,0,0, 32'h1000, 32'h1000, 1, 1, 2'd2, 16'hFFFF).e;
        ex[2] = mk(0,0,0,0, 32'h1000, 32'h1000, 1, 1, 2'd2, 16'hFFFF).e;
        drive(0, 1, 1, 32'h1000);
        repeat (65534) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            q.push_back(ex[i]);
            @(negedge clk);
            got = observe(); e = q.pop_front(); nvec++;
            if (got !== e) begin
                nerr++;
                $display("FAIL saturate[%0d] got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                         i, got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 32'h0);
        q.push_back(mk(0,0,0,0, 32'h1000, 32'h1004, 1, 1, 2'd2, 16'hFFFF).e);
        @(negedge clk);
        got = observe(); e = q.pop_front(); nvec++;
        if (got !== e) begin
            nerr++;
            $display("FAIL saturate_hold got pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h exp pc=%h nx=%h v=%b sq=%b st=%0d cnt=%h",
                     got.pc, got.nx, got.v, got.sq, got.st, got.cnt, e.pc, e.nx, e.v, e.sq, e.st, e.cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0);
        test_reset();
        test_taken_redirect();
        test_mispredict_flush();
        test_flush_stall();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
